mem_access_arbiter: RTL
=======================

Name: mem_access_arbiter

Overview:
- Shares the single-port main memory between two requesters: port 0 is the instruction-cache controller and port 1 is the data-cache controller.
- Arbitrates round-robin and latches the winning request.
- Sequences the memory read_en/write_en handshake: a single-word write-through store, or a 4-word line refill.
- Returns the response, with a timeout guard. Sits between the cache controllers and the main memory at the top level.

Parameters:
WIDTH, 32, data word width in bits
ADDR_W, 10, word address width (= $clog2 of memory DEPTH)
TIMEOUT, 64, max cycles to wait for mem_ready before flagging an error

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  2  per-requester request valid; held until the matching req_ready
req_write  input  2  per-requester op: 1 = word write, 0 = line read
req_addr  input  2*ADDR_W  per-requester word address, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  2*WIDTH  per-requester write data, requester i at [i*WIDTH +: WIDTH]
req_ready  output  2  one-cycle accept pulse, one-hot or zero
rsp_valid  output  2  one-cycle completion pulse to the owning requester
rsp_err  output  1  qualifies rsp_valid: 1 = timeout
rsp_data  output  4*WIDTH  line read data, valid with rsp_valid of a read
mem_address  output  ADDR_W  memory address
mem_write_en  output  1  memory write enable
mem_read_en  output  1  memory read enable
mem_write_data  output  WIDTH  memory write data
mem_ready  input  1  memory completion flag
mem_read_data  input  4*WIDTH  memory line data

Behaviour:
- Reset (sync, high):
  - State IDLE.
  - All outputs 0.
  - last_grant=1, so requester 0 wins first.
  - Timeout counter 0.
  - Reset mid-transaction aborts it: no rsp_valid, and the enables drop at that edge.
  - The memory's own active-low reset is driven from ~reset at the top level.
- FSM states: IDLE, ISSUE, RELEASE.
- IDLE:
  - If any req_valid: grant by round-robin. When both are valid, the requester != last_grant wins; a single valid requester always wins.
  - Pulse req_ready[g] this cycle (combinational from state and req_valid).
  - Capture op/addr/wdata/owner into registers; last_grant<=g; go ISSUE.
- ISSUE:
  - mem_address/mem_write_data come from the captured registers.
  - mem_write_en=op, mem_read_en=~op. Exactly one is high, never both.
  - Counter increments each cycle.
  - mem_ready==1: capture rsp_data<=mem_read_data (reads only; writes leave rsp_data unchanged) and go RELEASE with pulse_pending.
  - Counter reaches TIMEOUT-1 without mem_ready: go RELEASE with err flag set.
- RELEASE:
  - Both enables 0.
  - First cycle: rsp_valid[owner]=1 for exactly one cycle; rsp_err=err in that cycle; rsp_err is 0 at all other times.
  - Stay until mem_ready==0 (minimum 1 cycle), so a stale ready never completes the next transaction.
  - Then go IDLE and clear the counter.
  - RELEASE is also bounded by TIMEOUT: on expiry go IDLE with no extra pulse.
- Requests are accepted only in IDLE. req_valid arriving during ISSUE/RELEASE waits.
- Nominal latency with the current memory:
  - Write: accept at cycle 0, mem_write_en cycles 1-2, rsp_valid cycle 3, IDLE cycle 4.
  - Read: memory takes 4 edges; rsp_valid 6 cycles after accept.
  - Next accept is earliest in the cycle after RELEASE exits.
- Read address is passed unmodified; the memory line-aligns it.
- Back-to-back fairness: with both requesters continuously valid, grants strictly alternate.
- rsp_data holds its value until the next successful read.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ISSUE, RELEASE), NUM_REQ=2, LINE_WORDS=4, OP_READ/OP_WRITE constants.
- One sub-module: rr_arbiter2 (inputs req[1:0], last_grant; outputs one-hot grant, grant index), purely combinational.
- Pointer update stays in the parent.

Test Plan:
- Reset, then a single req0 write addr=0x010, wdata=0xDEADBEEF → req_ready[0] at cycle 0; mem_write_en=1, mem_address=0x010 from cycle 1; rsp_valid[0]=1 at cycle 3, rsp_err=0; memory word 0x010 = 0xDEADBEEF.
- req1 line read of addr 0x013 after words 0x010..0x013 are preloaded 1..4 → mem_read_en held until mem_ready; rsp_valid[1] one cycle; rsp_data equals mem_read_data sampled at ready.
- req0 and req1 both valid continuously for 4 transactions → grants 0,1,0,1; no overlap of enables; each rsp_valid goes to the correct owner.
- Memory model with ready tied low, TIMEOUT=8 → rsp_valid[owner] and rsp_err=1 at ISSUE cycle 8+1; FSM returns to IDLE; next request is accepted.
- reset asserted during ISSUE of a read → next edge: enables 0, no rsp_valid, state IDLE, last_grant=1.
- Stale ready: mem_ready forced high for 3 cycles after a write → FSM stays in RELEASE until low; following read not completed early.

Source files
------------

// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned LINE_WORDS = 4;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Requester and memory-side signals of the arbiter, grouped as one bus.
interface mem_arb_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 10
) ();
  import mem_arb_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_W-1:0]     req_addr;
  logic [NUM_REQ*WIDTH-1:0]      req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic                          rsp_err;
  logic [LINE_WORDS*WIDTH-1:0]   rsp_data;

  logic [ADDR_W-1:0]             mem_address;
  logic                          mem_write_en;
  logic                          mem_read_en;
  logic [WIDTH-1:0]              mem_write_data;
  logic                          mem_ready;
  logic [LINE_WORDS*WIDTH-1:0]   mem_read_data;

  // Arbiter side
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_ready, mem_read_data,
    output req_ready, rsp_valid, rsp_err, rsp_data,
           mem_address, mem_write_en, mem_read_en, mem_write_data
  );

  // Environment side (cache controllers + memory)
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_ready, mem_read_data,
    input  req_ready, rsp_valid, rsp_err, rsp_data,
           mem_address, mem_write_en, mem_read_en, mem_write_data
  );

endinterface

// File: rtl/mem_access_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester that did not win last time wins.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant_c,
  output logic       o_grant_idx_c
);

  always_comb begin
    o_grant_idx_c = 1'b0;
    o_grant_c     = 2'b00;
    if (i_req == 2'b11) begin
      o_grant_idx_c = ~i_last_grant;
    end else if (i_req[1]) begin
      o_grant_idx_c = 1'b1;
    end
    if (i_req != 2'b00) begin
      o_grant_c = o_grant_idx_c ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares single-port main memory between I-cache (port 0) and D-cache (port 1):
// round-robin accept, one memory op at a time, response pulse with timeout guard.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic     clk,
  input  logic     reset,
  mem_arb_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e                   r_state;
  logic                         r_last_grant;
  logic                         r_owner;
  logic                         r_op;
  logic [ADDR_W-1:0]            r_addr;
  logic [WIDTH-1:0]             r_wdata;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_we;
  logic                         r_re;
  logic [NUM_REQ-1:0]           r_rsp_valid;
  logic                         r_rsp_err;
  logic [LINE_WORDS*WIDTH-1:0]  r_rsp_data;

  logic [NUM_REQ-1:0]           w_grant;
  logic                         w_gidx;
  logic                         w_sel_op;
  logic [ADDR_W-1:0]            w_sel_addr;
  logic [WIDTH-1:0]             w_sel_wdata;
  logic [NUM_REQ-1:0]           w_owner_oh;

  rr_arbiter2 u_rr (
    .i_req         (bus.req_valid),
    .i_last_grant  (r_last_grant),
    .o_grant_c     (w_grant),
    .o_grant_idx_c (w_gidx)
  );

  // Winner's request fields
  assign w_sel_op    = bus.req_write[w_gidx];
  assign w_sel_addr  = w_gidx ? bus.req_addr[ADDR_W +: ADDR_W] : bus.req_addr[0 +: ADDR_W];
  assign w_sel_wdata = w_gidx ? bus.req_wdata[WIDTH +: WIDTH]  : bus.req_wdata[0 +: WIDTH];
  assign w_owner_oh  = {r_owner, ~r_owner};

  // Accept is only offered while idle
  assign bus.req_ready = (r_state == IDLE) ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_op         <= OP_READ;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_re         <= 1'b0;
      r_rsp_valid  <= '0;
      r_rsp_err    <= 1'b0;
      r_rsp_data   <= '0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|bus.req_valid) begin
            r_op         <= w_sel_op;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_owner      <= w_gidx;
            r_last_grant <= w_gidx;
            r_cnt        <= '0;
            r_we         <= (w_sel_op == OP_WRITE);
            r_re         <= (w_sel_op == OP_READ);
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_ready || (r_cnt == CNT_LAST)) begin
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= w_owner_oh;
            r_rsp_err   <= ~bus.mem_ready;
            if (bus.mem_ready && (r_op == OP_READ)) begin
              r_rsp_data <= bus.mem_read_data;
            end
            r_state     <= RELEASE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          // Wait out a lingering ready so it cannot complete the next op
          if (!bus.mem_ready || (r_cnt == CNT_LAST)) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_err        = r_rsp_err;
  assign bus.rsp_data       = r_rsp_data;
  assign bus.mem_address    = r_addr;
  assign bus.mem_write_data = r_wdata;
  assign bus.mem_write_en   = r_we;
  assign bus.mem_read_en    = r_re;

endmodule
